program_load_ctrl: RTL and testbench

- Boot-time sequencer that receives a program image as a UART byte stream and writes it word-by-word into program memory.
- Once the image is complete, it starts the CPU run and reports completion.
- Sits between the UART receiver and the program memory write port, and drives `run_flag` / `indication` toward the core and top level.

---
 rtl/program_load_ctrl.sv | 169 ++++++++++++++++
 tb/tb_program_load_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/program_load_ctrl.sv
// Boot loader: assembles a length-prefixed little-endian UART byte stream into 32-bit words,
// writes them to program memory, then releases the CPU and reports run completion.
module program_load_ctrl #(
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        run_finished,
  output logic        program_mem_write_enable,
  output logic [31:0] program_mem_write_data,
  output logic [31:0] uart_write_address,
  output logic        run_flag,
  output logic        indication,
  output logic        load_error
);

  typedef enum logic [1:0] {StLoadLen, StLoadData, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] word_idx_q, word_idx_d;
  logic [31:0] len_q, len_d;
  logic [31:0] gap_q, gap_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] addr_q, addr_d;
  logic        run_q, run_d;
  logic        ind_q, ind_d;
  logic        err_q, err_d;

  logic [31:0] word_full;
  logic        data_done;
  logic        gap_active;
  logic        expire;

  // The 4th byte completes the word directly, without waiting for the shift register update.
  assign word_full  = {rx_data, shift_q[23:0]};
  assign data_done  = (word_idx_q == len_q);
  assign gap_active = ((state_q == StLoadLen) && (byte_cnt_q != 2'd0)) ||
                      ((state_q == StLoadData) && !data_done);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    word_idx_d = word_idx_q;
    len_d      = len_q;
    gap_d      = 32'd0;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    run_d      = run_q;
    ind_d      = ind_q;
    err_d      = err_q;
    expire     = 1'b0;

    // A byte arriving on the expiry cycle wins over the timeout.
    if (gap_active && !rx_valid) begin
      if (gap_q == 32'(TIMEOUT_CYCLES - 1)) begin
        expire = 1'b1;
      end else begin
        gap_d = gap_q + 32'd1;
      end
    end

    unique case (state_q)
      StLoadLen: begin
        if (rx_valid) begin
          err_d                              = 1'b0;
          shift_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
          byte_cnt_d                         = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if ((word_full == 32'd0) || (word_full > MAX_WORDS)) begin
              err_d = 1'b1;
            end else begin
              len_d      = word_full;
              word_idx_d = 32'd0;
              state_d    = StLoadData;
            end
          end
        end
      end
      StLoadData: begin
        // data_done first becomes true during the final write strobe cycle.
        if (data_done) begin
          state_d = StRun;
          run_d   = 1'b1;
        end else if (rx_valid) begin
          err_d                              = 1'b0;
          shift_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
          byte_cnt_d                         = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            wdata_d    = word_full;
            addr_d     = BASE_ADDR + {word_idx_q[29:0], 2'b00};
            word_idx_d = word_idx_q + 32'd1;
          end
        end
      end
      StRun: begin
        if (run_finished) begin
          run_d   = 1'b0;
          ind_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (rx_valid) begin
          ind_d         = 1'b0;
          err_d         = 1'b0;
          shift_d[7:0]  = rx_data;
          byte_cnt_d    = 2'd1;
          state_d       = StLoadLen;
        end
      end
      default: state_d = StLoadLen;
    endcase

    if (expire) begin
      err_d      = 1'b1;
      state_d    = StLoadLen;
      byte_cnt_d = 2'd0;
      word_idx_d = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StLoadLen;
      byte_cnt_q <= 2'd0;
      shift_q    <= 32'd0;
      word_idx_q <= 32'd0;
      len_q      <= 32'd0;
      gap_q      <= 32'd0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      addr_q     <= 32'd0;
      run_q      <= 1'b0;
      ind_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      word_idx_q <= word_idx_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      run_q      <= run_d;
      ind_q      <= ind_d;
      err_q      <= err_d;
    end
  end

  assign program_mem_write_enable = we_q;
  assign program_mem_write_data   = wdata_q;
  assign uart_write_address       = addr_q;
  assign run_flag                 = run_q;
  assign indication               = ind_q;
  assign load_error               = err_q;

endmodule

// File: tb/tb_program_load_ctrl.sv
// Directed bench for program_load_ctrl: image loads, run handshake, length errors,
// gap timeout edge, and asynchronous reset mid-load.
module tb_program_load_ctrl;

  localparam int unsigned To = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        run_finished = 1'b0;
  logic        program_mem_write_enable;
  logic [31:0] program_mem_write_data;
  logic [31:0] uart_write_address;
  logic        run_flag;
  logic        indication;
  logic        load_error;

  program_load_ctrl #(
    .MAX_WORDS     (1024),
    .TIMEOUT_CYCLES(To),
    .BASE_ADDR     (32'h0000_0000)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .rx_valid                (rx_valid),
    .rx_data                 (rx_data),
    .run_finished            (run_finished),
    .program_mem_write_enable(program_mem_write_enable),
    .program_mem_write_data  (program_mem_write_data),
    .uart_write_address      (uart_write_address),
    .run_flag                (run_flag),
    .indication              (indication),
    .load_error              (load_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;

  always @(negedge clk) if (program_mem_write_enable) wr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic expect_wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, "_we"}, 32'(program_mem_write_enable), 32'd1);
    check({tag, "_addr"}, uart_write_address, addr);
    check({tag, "_data"}, program_mem_write_data, data);
  endtask

  task automatic finish_run(input string tag);
    check({tag, "_run_pre"}, 32'(run_flag), 32'd1);
    run_finished = 1'b1;
    tick();
    run_finished = 1'b0;
    check({tag, "_run_post"}, 32'(run_flag), 32'd0);
    check({tag, "_ind"}, 32'(indication), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"}, 32'(program_mem_write_enable), 32'd0);
    check({tag, "_data"}, program_mem_write_data, 32'd0);
    check({tag, "_addr"}, uart_write_address, 32'd0);
    check({tag, "_run"}, 32'(run_flag), 32'd0);
    check({tag, "_ind"}, 32'(indication), 32'd0);
    check({tag, "_err"}, 32'(load_error), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    #12;
    check_zero("reset");
    reset_n = 1'b1;
    tick();

    // Two-word image, back-to-back bytes
    send_word(32'd2);
    send_word(32'h0000_0013);
    expect_wr("w0", 32'h0, 32'h0000_0013);
    send_word(32'h0010_0093);
    expect_wr("w1", 32'h4, 32'h0010_0093);
    check("run_not_yet", 32'(run_flag), 32'd0);
    tick();
    check("we_single", 32'(program_mem_write_enable), 32'd0);
    check("run_rise", 32'(run_flag), 32'd1);

    // Byte during RUN is dropped
    send(8'hFF);
    check("run_drop_we", 32'(program_mem_write_enable), 32'd0);
    check("run_wr_cnt", 32'(wr_cnt), 32'd2);
    finish_run("run1");
    tick();
    tick();
    check("done_hold", 32'(indication), 32'd1);
    send(8'h01);
    check("ind_clear", 32'(indication), 32'd0);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    send_word(32'h1234_5678);
    expect_wr("reload", 32'h0, 32'h1234_5678);
    tick();
    finish_run("run2");

    // Length errors
    send_word(32'd0);
    check("len_zero_err", 32'(load_error), 32'd1);
    check("len_zero_ind", 32'(indication), 32'd0);
    run_finished = 1'b1;
    tick();
    run_finished = 1'b0;
    check("rf_ignored_ind", 32'(indication), 32'd0);
    check("rf_ignored_run", 32'(run_flag), 32'd0);
    check("err_sticky", 32'(load_error), 32'd1);
    send(8'h01);
    check("err_clear_byte", 32'(load_error), 32'd0);
    send(8'h04);
    send(8'h00);
    send(8'h00);
    check("len_big_err", 32'(load_error), 32'd1);
    check("len_err_no_wr", 32'(wr_cnt), 32'd3);
    send_word(32'd1);
    check("err_clear_img", 32'(load_error), 32'd0);
    send_word(32'hDDCC_BBAA);
    expect_wr("after_err", 32'h0, 32'hDDCC_BBAA);
    tick();
    finish_run("run3");

    // Gap timeout after 2 data bytes (MAX_WORDS itself accepted)
    send_word(32'd1024);
    check("len_max_ok", 32'(load_error), 32'd0);
    send(8'hAA);
    send(8'hBB);
    repeat (To - 1) tick();
    check("no_early_to", 32'(load_error), 32'd0);
    tick();
    check("timeout_err", 32'(load_error), 32'd1);
    check("timeout_no_wr", 32'(wr_cnt), 32'd4);
    send_word(32'd1);
    send_word(32'h4433_2211);
    expect_wr("after_to", 32'h0, 32'h4433_2211);
    check("after_to_err", 32'(load_error), 32'd0);
    tick();
    finish_run("run4");

    // Byte arrives exactly on the expiry cycle
    send_word(32'd1);
    send(8'h55);
    repeat (To - 1) tick();
    send(8'h66);
    check("edge_no_err", 32'(load_error), 32'd0);
    send(8'h77);
    send(8'h88);
    expect_wr("edge", 32'h0, 32'h8877_6655);
    check("edge_err2", 32'(load_error), 32'd0);
    tick();
    finish_run("run5");

    // Async reset after 3 of 5 words
    send_word(32'd5);
    send_word(32'hA0A0_A0A0);
    expect_wr("r0", 32'h0, 32'hA0A0_A0A0);
    send_word(32'hB1B1_B1B1);
    expect_wr("r1", 32'h4, 32'hB1B1_B1B1);
    send_word(32'hC2C2_C2C2);
    expect_wr("r2", 32'h8, 32'hC2C2_C2C2);
    send(8'hAB);
    send(8'hCD);
    #2 reset_n = 1'b0;
    #1 check_zero("async_rst");
    #3 reset_n = 1'b1;
    tick();
    send_word(32'd1);
    send_word(32'h0403_0201);
    expect_wr("post_rst", 32'h0, 32'h0403_0201);
    tick();
    check("post_rst_run", 32'(run_flag), 32'd1);
    check("total_wr", 32'(wr_cnt), 32'd10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
